// File: rtl/shift_rows_stream.sv
// Streaming Rijndael ShiftRows/InvShiftRows stage (NB = 4/6/8 columns) with an OUT + SKID output buffer.
// Optional per-byte parity checking is enabled by defining SHIFT_ROWS_PARITY_EN.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode_inv,
    input  logic [32*NB-1:0]    state_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    state_out,
    output logic                busy,
    output logic [CNT_W-1:0]    blk_cnt
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    input  logic [4*NB-1:0]     par_in,
    output logic                par_err
`endif
);

    localparam int W   = 32 * NB;
    localparam int NBY = 4 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    // Row offset; the 256-bit state uses a wider spread for rows 2 and 3.
    function automatic int row_offset(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end else begin
            return r;
        end
    endfunction

    function automatic int src_byte(input int k, input logic inv);
        int r;
        int c;
        int sc;
        r = k % 4;
        c = k / 4;
        if (inv) begin
            sc = (c - row_offset(r) + NB) % NB;
        end else begin
            sc = (c + row_offset(r)) % NB;
        end
        return 4 * sc + r;
    endfunction

    function automatic logic [W-1:0] shift_state(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] o;
        o = '0;
        for (int k = 0; k < NBY; k++) begin
            o[W-1-8*k -: 8] = s[W-1-8*src_byte(k, inv) -: 8];
        end
        return o;
    endfunction

    logic             in_xfer_s;
    logic             out_free_s;
    logic [W-1:0]     perm_data_s;
    logic [W-1:0]     out_data_r,  out_data_s;
    logic [W-1:0]     skid_data_r, skid_data_s;
    logic             out_valid_r, out_valid_s;
    logic             skid_valid_r, skid_valid_s;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r;

    assign in_xfer_s   = in_valid & in_ready_r;
    assign out_free_s  = ~out_valid_r | out_ready;
    assign perm_data_s = shift_state(state_in, mode_inv);

`ifdef SHIFT_ROWS_PARITY_EN
    // Parity bits follow their bytes through the same permutation.
    function automatic logic [NBY-1:0] shift_par(input logic [NBY-1:0] p, input logic inv);
        logic [NBY-1:0] o;
        o = '0;
        for (int k = 0; k < NBY; k++) begin
            o[k] = p[src_byte(k, inv)];
        end
        return o;
    endfunction

    function automatic logic parity_bad(input logic [W-1:0] d, input logic [NBY-1:0] p);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NBY; k++) begin
            bad = bad | ((^d[W-1-8*k -: 8]) ^ p[k]);
        end
        return bad;
    endfunction

    logic [NBY-1:0] perm_par_s;
    logic [NBY-1:0] out_par_r,  out_par_s;
    logic [NBY-1:0] skid_par_r, skid_par_s;
    logic           par_err_r,  par_err_s;

    assign perm_par_s = shift_par(par_in, mode_inv);
`endif

    // Next-state of the OUT/SKID pair: SKID drains first, then a fresh accept, else OUT empties.
    always_comb begin
        out_data_s   = out_data_r;
        out_valid_s  = out_valid_r;
        skid_data_s  = skid_data_r;
        skid_valid_s = skid_valid_r;
`ifdef SHIFT_ROWS_PARITY_EN
        out_par_s    = out_par_r;
        skid_par_s   = skid_par_r;
`endif
        if (out_free_s) begin
            if (skid_valid_r) begin
                out_data_s   = skid_data_r;
                out_valid_s  = 1'b1;
                skid_valid_s = 1'b0;
`ifdef SHIFT_ROWS_PARITY_EN
                out_par_s    = skid_par_r;
`endif
            end else if (in_xfer_s) begin
                out_data_s  = perm_data_s;
                out_valid_s = 1'b1;
`ifdef SHIFT_ROWS_PARITY_EN
                out_par_s   = perm_par_s;
`endif
            end else begin
                out_valid_s = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                skid_data_s  = perm_data_s;
                skid_valid_s = 1'b1;
`ifdef SHIFT_ROWS_PARITY_EN
                skid_par_s   = perm_par_s;
`endif
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

`ifdef SHIFT_ROWS_PARITY_EN
    // Flag is raised together with the faulty block landing in OUT, then held.
    always_comb begin
        par_err_s = par_err_r | (out_valid_s & parity_bad(out_data_s, out_par_s));
    end
`endif

    // State registers, block counter and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r   <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
`ifdef SHIFT_ROWS_PARITY_EN
            out_par_r    <= {NBY{1'b0}};
            skid_par_r   <= {NBY{1'b0}};
            par_err_r    <= 1'b0;
`endif
        end else begin
            out_data_r   <= out_data_s;
            skid_data_r  <= skid_data_s;
            out_valid_r  <= out_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            if (in_xfer_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
`ifdef SHIFT_ROWS_PARITY_EN
            out_par_r    <= out_par_s;
            skid_par_r   <= skid_par_s;
            par_err_r    <= par_err_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign state_out = out_data_r;
    assign busy      = out_valid_r | skid_valid_r;
    assign blk_cnt   = cnt_r;
`ifdef SHIFT_ROWS_PARITY_EN
    assign par_err   = par_err_r;
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// Randomised + directed bench for shift_rows_stream: NB=4 (CNT_W=4) and NB=8 instances against a queue-based model.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid4, in_ready4, mode4, out_valid4, out_ready4, busy4;
    logic [127:0] st_in4, st_out4;
    logic [3:0]   cnt4;
    logic         in_valid8, in_ready8, mode8, out_valid8, out_ready8, busy8;
    logic [255:0] st_in8, st_out8;
    logic [15:0]  cnt8;
`ifdef SHIFT_ROWS_PARITY_EN
    logic [15:0]  par_in4, flip4;
    logic [31:0]  par_in8;
    logic         par_err4, par_err8, perr_exp4;
`endif

    shift_rows_stream #(.NB(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .mode_inv(mode4),
        .state_in(st_in4), .out_valid(out_valid4), .out_ready(out_ready4), .state_out(st_out4),
        .busy(busy4), .blk_cnt(cnt4)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_in(par_in4), .par_err(par_err4)
`endif
    );

    shift_rows_stream #(.NB(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .mode_inv(mode8),
        .state_in(st_in8), .out_valid(out_valid8), .out_ready(out_ready8), .state_out(st_out8),
        .busy(busy8), .blk_cnt(cnt8)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_in(par_in8), .par_err(par_err8)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] q4[$];
    logic [255:0] q8[$];
    logic [3:0]   cnt4_m;
    logic [15:0]  cnt8_m;
    logic         hold4, hold8;
    logic [127:0] hold4_d;
    logic [255:0] hold8_d;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: states are right-aligned; each row is rotated as a queue.
    function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input logic inv);
        logic [7:0]   row[$];
        logic [255:0] o;
        int           sh;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(s[32*nb-1-8*(4*c+r) -: 8]);
            sh = (nb == 8 && r >= 2) ? r + 1 : r;
            repeat (sh) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) o[32*nb-1-8*(4*c+r) -: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [255:0] mk_seq(input int nb);
        logic [255:0] s;
        s = '0;
        for (int k = 0; k < 4*nb; k++) s[32*nb-1-8*k -: 8] = 8'(k);
        return s;
    endfunction

`ifdef SHIFT_ROWS_PARITY_EN
    function automatic logic [31:0] par_of(input logic [255:0] s, input int nb);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 4*nb; k++) p[k] = ^s[32*nb-1-8*k -: 8];
        return p;
    endfunction
`endif

    // One clock: score transfers due at the next edge, advance, then compare observable state with the model.
    task automatic tick();
        logic [255:0] e;
`ifdef SHIFT_ROWS_PARITY_EN
        par_in4 = 16'(par_of(256'(st_in4), 4)) ^ flip4;
        par_in8 = par_of(st_in8, 8);
`endif
        if (hold4) begin
            check("hold4_v", 256'(out_valid4), 256'(1'b1));
            check("hold4_d", 256'(st_out4), 256'(hold4_d));
        end
        if (hold8) begin
            check("hold8_v", 256'(out_valid8), 256'(1'b1));
            check("hold8_d", st_out8, hold8_d);
        end
        if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) check("extra4", 256'(out_valid4), 256'(1'b0));
            else begin e = q4.pop_front(); check("data4", 256'(st_out4), e); end
        end
        if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) check("extra8", 256'(out_valid8), 256'(1'b0));
            else begin e = q8.pop_front(); check("data8", st_out8, e); end
        end
        if (in_valid4 && in_ready4) begin q4.push_back(ref_shift(256'(st_in4), 4, mode4)); cnt4_m++; end
        if (in_valid8 && in_ready8) begin q8.push_back(ref_shift(st_in8, 8, mode8)); cnt8_m++; end
        hold4 = out_valid4 && !out_ready4; hold4_d = st_out4;
        hold8 = out_valid8 && !out_ready8; hold8_d = st_out8;
        @(negedge clk);
        check("cnt4",   256'(cnt4),       256'(cnt4_m));
        check("busy4",  256'(busy4),      256'(q4.size() != 0));
        check("oval4",  256'(out_valid4), 256'(q4.size() != 0));
        check("irdy4",  256'(in_ready4),  256'(q4.size() < 2));
        check("cnt8",   256'(cnt8),       256'(cnt8_m));
        check("busy8",  256'(busy8),      256'(q8.size() != 0));
        check("irdy8",  256'(in_ready8),  256'(q8.size() < 2));
`ifdef SHIFT_ROWS_PARITY_EN
        check("perr4",  256'(par_err4),   256'(perr_exp4));
        check("perr8",  256'(par_err8),   256'(1'b0));
`endif
    endtask

    task automatic do_reset();
        in_valid4 = 1'b0; in_valid8 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_oval4", 256'(out_valid4), 256'(1'b0));
        check("rst_data4", 256'(st_out4),    256'(0));
        check("rst_cnt4",  256'(cnt4),       256'(0));
        check("rst_busy4", 256'(busy4),      256'(1'b0));
        check("rst_irdy4", 256'(in_ready4),  256'(1'b0));
        check("rst_oval8", 256'(out_valid8), 256'(1'b0));
        check("rst_cnt8",  256'(cnt8),       256'(0));
        check("rst_irdy8", 256'(in_ready8),  256'(1'b0));
        q4.delete(); q8.delete();
        cnt4_m = '0; cnt8_m = '0; hold4 = 1'b0; hold8 = 1'b0;
`ifdef SHIFT_ROWS_PARITY_EN
        perr_exp4 = 1'b0;
        check("rst_perr4", 256'(par_err4), 256'(1'b0));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_irdy4", 256'(in_ready4), 256'(1'b1));
        check("post_irdy8", 256'(in_ready8), 256'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] seq4, seq8, t1, blk_a;
        in_valid4 = 1'b0; out_ready4 = 1'b0; mode4 = 1'b0; st_in4 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; st_in8 = '0;
`ifdef SHIFT_ROWS_PARITY_EN
        flip4 = '0; perr_exp4 = 1'b0; par_in4 = '0; par_in8 = '0;
`endif
        seq4 = mk_seq(4);
        seq8 = mk_seq(8);
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Known-answer vectors, forward then inverse, then round trip.
        out_ready4 = 1'b1; in_valid4 = 1'b1; st_in4 = seq4[127:0]; mode4 = 1'b0;
        tick();
        check("kat_fwd4", 256'(st_out4), 256'(128'h00050A0F_04090E03_080D0207_0C01060B));
        check("kat_cnt4", 256'(cnt4), 256'(4'd1));
        mode4 = 1'b1;
        tick();
        check("kat_inv4", 256'(st_out4), 256'(128'h000D0A07_04010E0B_0805020F_0C090603));
        st_in4 = 128'h00050A0F_04090E03_080D0207_0C01060B;
        tick();
        check("kat_rt4", 256'(st_out4), seq4);
        in_valid4 = 1'b0;
        tick();

        // NB=8 forward then inverse back-to-back.
        out_ready8 = 1'b1; in_valid8 = 1'b1; st_in8 = seq8; mode8 = 1'b0;
        tick();
        check("kat_fwd8", 256'(st_out8[247:224]), 256'(24'h050E13));
        t1 = ref_shift(seq8, 8, 1'b0);
        st_in8 = t1; mode8 = 1'b1;
        tick();
        check("kat_rt8", st_out8, seq8);
        in_valid8 = 1'b0;
        tick();

        // Backpressure: A and B accepted, C held, then drained in order.
        out_ready4 = 1'b0; in_valid4 = 1'b1; mode4 = 1'b0;
        st_in4 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF; tick();
        st_in4 = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF; tick();
        st_in4 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF; mode4 = 1'b1;
        tick(); tick();
        check("bp_irdy4", 256'(in_ready4), 256'(1'b0));
        check("bp_held4", 256'(q4.size()), 256'(2));
        out_ready4 = 1'b1;
        tick(); tick();
        in_valid4 = 1'b0;
        tick(); tick();

        // Mid-stream reset with both registers full.
        out_ready4 = 1'b0; in_valid4 = 1'b1; st_in4 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tick(); tick();
        check("full_busy4", 256'(busy4), 256'(1'b1));
        do_reset();
        in_valid4 = 1'b1; out_ready4 = 1'b1; mode4 = 1'b0;
        blk_a = ref_shift(256'(st_in4), 4, 1'b0);
        tick();
        check("rst_lat4", 256'(out_valid4), 256'(1'b1));
        check("rst_blk4", 256'(st_out4), blk_a);
        in_valid4 = 1'b0;
        tick();

        // Counter wrap with CNT_W=4.
        do_reset();
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            st_in4 = 128'({$urandom(), $urandom(), $urandom(), $urandom()});
            mode4 = 1'($urandom_range(0, 1));
            tick();
        end
        check("wrap4", 256'(cnt4), 256'(4'd1));
        in_valid4 = 1'b0;
        tick();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid4 && !in_ready4)) begin
                st_in4 = 128'({$urandom(), $urandom(), $urandom(), $urandom()});
                mode4  = 1'($urandom_range(0, 1));
                in_valid4 = ($urandom_range(0, 9) < 7);
            end
            if (!(in_valid8 && !in_ready8)) begin
                st_in8 = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                mode8  = 1'($urandom_range(0, 1));
                in_valid8 = ($urandom_range(0, 9) < 7);
            end
            out_ready4 = ($urandom_range(0, 9) < 6);
            out_ready8 = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid4 = 1'b0; in_valid8 = 1'b0; out_ready4 = 1'b1; out_ready8 = 1'b1;
        for (int i = 0; i < 8 && (q4.size() != 0 || q8.size() != 0); i++) tick();
        check("drained", 256'(q4.size() + q8.size()), 256'(0));

`ifdef SHIFT_ROWS_PARITY_EN
        // A single corrupted parity bit raises a sticky error.
        do_reset();
        in_valid4 = 1'b1; out_ready4 = 1'b1; st_in4 = seq4[127:0]; mode4 = 1'b0;
        flip4 = 16'h0010; perr_exp4 = 1'b1;
        tick();
        flip4 = '0; in_valid4 = 1'b0;
        repeat (3) tick();
        check("perr_sticky", 256'(par_err4), 256'(1'b1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
